// File: rtl/hazard_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_predict_unit
// Description : Pipeline hazard unit: operand forwarding, load-use and
//               multi-cycle stalls, redirect flushes, 2-bit BHT predictor
//               and a mispredict counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_predict_unit #(
    parameter int REG_W     = 5,
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 4,
    parameter int MUL_LAT   = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             MulE,
    input  logic [XLEN-1:0]  PCF,
    input  logic [XLEN-1:0]  PCE,
    input  logic             BranchE,
    input  logic             TakenE,
    input  logic             PredictedE,
    input  logic             JumpE,
    output logic             PredictTakenF,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MispredictE,
    output logic [CNT_W-1:0] MispredCount
);

    localparam int               C_BHT_DEPTH = 2 ** BHT_IDX_W;
    localparam logic [2:0]       C_MCNT_LAST = 3'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    logic [1:0]           r_bht [C_BHT_DEPTH];
    logic [2:0]           r_mcnt;
    logic [CNT_W-1:0]     r_mispredCount;
    logic                 w_lwStall;
    logic                 w_mulStall;
    logic                 w_redirect;
    logic [BHT_IDX_W-1:0] w_idxF;
    logic [BHT_IDX_W-1:0] w_idxE;
    logic                 w_unusedPcBits;

    assign w_idxF         = PCF[BHT_IDX_W+1:2];
    assign w_idxE         = PCE[BHT_IDX_W+1:2];
    assign w_unusedPcBits = ^{PCF[XLEN-1:BHT_IDX_W+2], PCF[1:0],
                              PCE[XLEN-1:BHT_IDX_W+2], PCE[1:0]};

    // M-stage result has priority over W-stage result; x0 never forwards.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (Rs1E == RdM) && (Rs1E != '0))
            ForwardAE = 2'b10;
        else if (RegWriteW && (Rs1E == RdW) && (Rs1E != '0))
            ForwardAE = 2'b01;
        if (RegWriteM && (Rs2E == RdM) && (Rs2E != '0))
            ForwardBE = 2'b10;
        else if (RegWriteW && (Rs2E == RdW) && (Rs2E != '0))
            ForwardBE = 2'b01;
    end

    assign w_lwStall  = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign MispredictE = BranchE && (TakenE != PredictedE);
    assign w_redirect = MispredictE || JumpE;
    assign w_mulStall = MulE && (r_mcnt != C_MCNT_LAST);

    assign StallE = w_mulStall;
    assign FlushM = w_mulStall;
    assign StallF = (w_lwStall && !w_redirect) || w_mulStall;
    assign StallD = (w_lwStall && !w_redirect) || w_mulStall;
    assign FlushD = w_redirect && !w_mulStall;
    assign FlushE = (w_lwStall || w_redirect) && !w_mulStall;

    assign PredictTakenF = reset_n && r_bht[w_idxF][1];
    assign MispredCount  = r_mispredCount;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_mcnt <= 3'd0;
        else if (w_mulStall)
            r_mcnt <= r_mcnt + 3'd1;
        else
            r_mcnt <= 3'd0;
    end

    // Branch resolution is held off while E is frozen so a stalled branch trains once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < C_BHT_DEPTH; i++)
                r_bht[i] <= 2'b01;
        end else if (BranchE && !w_mulStall) begin
            if (TakenE) begin
                if (r_bht[w_idxE] != 2'b11)
                    r_bht[w_idxE] <= r_bht[w_idxE] + 2'd1;
            end else begin
                if (r_bht[w_idxE] != 2'b00)
                    r_bht[w_idxE] <= r_bht[w_idxE] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_mispredCount <= '0;
        else if (MispredictE && !w_mulStall)
            r_mispredCount <= r_mispredCount + C_CNT_ONE;
    end

endmodule
`default_nettype wire
